// File: rtl/mic_record_ctrl.sv
// PDM microphone record controller: gated mic clock, warm-up, ones-count decimation,
// and sequential writes of 8-bit PCM samples into the sample RAM.
module mic_record_ctrl #(
   parameter int unsigned DIV_HALF = 20,
   parameter int unsigned WARM     = 256,
   parameter int unsigned DEC      = 255,
   parameter int unsigned ADDR_W   = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] len,
   input  logic              pdm_data,
   output logic              mic_clk,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              done,
   output logic              led
);

   typedef enum logic [1:0] {StIdle, StWarmup, StCapture, StDone} state_e;

   localparam logic [15:0]       CntReload = 16'(DIV_HALF - 1);
   localparam logic [15:0]       WarmLast  = 16'(WARM - 1);
   localparam logic [7:0]        DecLast   = 8'(DEC - 1);
   localparam logic [ADDR_W-1:0] AddrOne   = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              mic_clk_q, mic_clk_d;
   logic [15:0]       warm_q, warm_d;
   logic [7:0]        bit_q, bit_d;
   logic [7:0]        ones_q, ones_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              wr_en_q, wr_en_d;
   logic              sync1_q, pdm_s_q;
   logic              running;
   logic              rise;
   logic [ADDR_W-1:0] last_addr;

   assign running   = (state_q == StWarmup) || (state_q == StCapture);
   assign rise      = running && (cnt_q == 16'd0) && !mic_clk_q;
   // len == 0 wraps to all-ones, giving a full 2^ADDR_W sample recording
   assign last_addr = len_q - AddrOne;

   // Two-flop synchroniser for the asynchronous PDM data pin
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         pdm_s_q <= 1'b0;
      end else begin
         sync1_q <= pdm_data;
         pdm_s_q <= sync1_q;
      end
   end

   // State register for the FSM, divider, counters and write port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= 16'd0;
         mic_clk_q <= 1'b0;
         warm_q    <= 16'd0;
         bit_q     <= 8'd0;
         ones_q    <= 8'd0;
         len_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= 8'd0;
         wr_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mic_clk_q <= mic_clk_d;
         warm_q    <= warm_d;
         bit_q     <= bit_d;
         ones_q    <= ones_d;
         len_q     <= len_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
      end
   end

   // Next-state logic: divider, warm-up count, decimation and RAM write sequencing
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mic_clk_d = mic_clk_q;
      warm_d    = warm_q;
      bit_d     = bit_q;
      ones_d    = ones_q;
      len_d     = len_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;

      if (running) begin
         if (cnt_q == 16'd0) begin
            mic_clk_d = ~mic_clk_q;
            cnt_d     = CntReload;
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
      end

      unique case (state_q)
         StIdle: begin
            mic_clk_d = 1'b0;
            if (start) begin
               len_d     = len;
               wr_addr_d = '0;
               bit_d     = 8'd0;
               ones_d    = 8'd0;
               warm_d    = 16'd0;
               cnt_d     = CntReload;
               state_d   = StWarmup;
            end
         end
         StWarmup: begin
            if (stop) begin
               state_d = StDone;
            end else if (rise) begin
               if (warm_q == WarmLast) begin
                  state_d = StCapture;
               end else begin
                  warm_d = warm_q + 16'd1;
               end
            end
         end
         StCapture: begin
            // A write already on the bus still counts even if stop arrives now
            if (wr_en_q) begin
               wr_addr_d = wr_addr_q + AddrOne;
            end
            if (stop) begin
               state_d = StDone;
            end else begin
               if (wr_en_q && (wr_addr_q == last_addr)) begin
                  state_d = StDone;
               end
               if (rise) begin
                  if (bit_q == DecLast) begin
                     wr_en_d   = 1'b1;
                     wr_data_d = ones_q + {7'd0, pdm_s_q};
                     bit_d     = 8'd0;
                     ones_d    = 8'd0;
                  end else begin
                     bit_d  = bit_q + 8'd1;
                     ones_d = ones_q + {7'd0, pdm_s_q};
                  end
               end
            end
         end
         StDone: begin
            mic_clk_d = 1'b0;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // mic_clk is masked outside the running states so DONE always shows it low
   assign mic_clk = mic_clk_q & running;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign busy    = running;
   assign led     = running;
   assign done    = (state_q == StDone);

endmodule

// File: doc/mic_record_ctrl.md
# mic_record_ctrl

Record controller for the PDM MEMS microphone path of the PCM audio subsystem. Generates the gated microphone clock, waits out the mic start-up time, samples and synchronises the PDM bit stream, decimates it by ones-counting into 8-bit PCM samples, and writes a programmed number of samples into the audio sample RAM through a single write port. Sits between the board microphone pins and the sample RAM. The playback side later reads that RAM.

## Interface
Parameters:
- DIV_HALF, 20, system clocks per mic_clk half-period; mic_clk = clk/(2*DIV_HALF). Allowed range 1..65535.
- WARM, 256, mic_clk rising edges discarded after start before capture begins. Allowed range 1..65535.
- DEC, 255, PDM bits per PCM sample. Allowed range 1..255.
- ADDR_W, 15, sample RAM address width.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high. Clears all state.
- start  in  1  one-cycle request to begin a recording. Accepted only in IDLE.
- stop  in  1  abort request. Honoured in WARMUP and CAPTURE.
- len  in  ADDR_W  number of samples to record; 0 means 2^ADDR_W. Sampled when start is accepted.
- pdm_data  in  1  microphone data pin, asynchronous.
- mic_clk  out  1  microphone clock.
- wr_en  out  1  sample RAM write strobe, one cycle.
- wr_addr  out  ADDR_W  sample RAM address, valid with wr_en.
- wr_data  out  8  PCM sample, valid with wr_en.
- busy  out  1  high in WARMUP and CAPTURE.
- done  out  1  one-cycle pulse at the end of a recording (completed or aborted).
- led  out  1  equals busy. Recording indicator.

## Operation
- Reset values: mic_clk 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, led 0, state IDLE.
- pdm_data passes through a 2-FF synchroniser to give pdm_s.
- FSM states: IDLE → WARMUP → CAPTURE → DONE → IDLE.
- IDLE: mic_clk is held at 0 and the divider is stopped. When start is seen, the block loads len, clears wr_addr, the bit counter, the ones counter and the warm-up counter, sets cnt = DIV_HALF-1, and moves to WARMUP. stop is ignored in IDLE.
- Divider, running in WARMUP and CAPTURE:
  - Each clk: if cnt == 0, toggle mic_clk and reload cnt = DIV_HALF-1; otherwise decrement cnt.
  - A "rise event" is a cycle with cnt == 0 and mic_clk == 0.
- WARMUP: each rise event increments the warm-up counter. On the WARM-th rise event, move to CAPTURE. The divider keeps running without a phase reset.
- CAPTURE: on each rise event, add pdm_s to the ones counter and increment the bit counter.
  - On the DEC-th bit, on the following edge: wr_data = ones count including that bit (0..DEC), wr_en = 1, and both counters clear.
  - wr_addr increments on the edge after each write.
  - When the write just issued is at address len-1 (mod 2^ADDR_W), move to DONE on the same edge as the address increment.
- stop in WARMUP or CAPTURE: on the next edge, go to DONE. A partial sample is discarded and produces no write. stop has priority over a write that would issue on that same edge. wr_addr then holds the number of samples written.
- DONE: lasts one cycle. done = 1, mic_clk is forced to 0, then the FSM returns to IDLE. start is ignored in DONE.
- Asserting reset mid-operation immediately returns every output to its reset value. No partial write is issued.

## Timing
- Start-to-first-rise: start accepted at edge E. The first mic_clk rise happens at edge E + DIV_HALF.
- mic_clk period is 2*DIV_HALF clks with 50 % duty cycle.
- Sample period: DEC*2*DIV_HALF clks.
- wr_en is high for exactly 1 cycle per sample. wr_addr and wr_data are stable during that cycle.
- Data latency: pdm_data is seen 2 clks late through the synchroniser. A pdm_data level must be stable for at least 3 clks before a rise event to be counted.
- First write occurs 1 clk after the rise event of bit DEC of the first capture window.
- done occurs 1 clk after the last write.
- Total recording length with no stop: (DIV_HALF + (WARM + len*DEC - 1)*2*DIV_HALF) clks from start acceptance to the final rise event, then +1 clk to wr_en and +1 clk to done.

## Test plan
Parameters for the bench: DIV_HALF=2, WARM=4, DEC=4, ADDR_W=4.

- Constant 1 on pdm_data, len=3, start pulse:
  - mic_clk period is 4 clks.
  - 4 rises are discarded.
  - wr_en pulses at addresses 0, 1, 2, each with data 4, spaced 16 clks apart.
  - done pulses 1 clk after the third write; busy falls; mic_clk stays 0.
- pdm_data alternating 1,0 per mic bit, len=2: writes carry data 2, 2.
- pdm_data constant 0, len=0: exactly 16 writes at addresses 0..15, each with data 0. wr_addr wraps to 0, then done.
- stop asserted 5 clks after the first write, len=3:
  - no further wr_en;
  - done the next cycle;
  - wr_addr = 1.
- start held high through a recording and through the DONE cycle: only one recording runs, and a new one starts on the IDLE cycle after done.
- reset asserted mid-CAPTURE:
  - all outputs go to 0 asynchronously and mic_clk stops;
  - after reset is released with no start, no wr_en occurs for 200 clks.
